// File: rtl/pipelined_array_mult_pkg.sv
// Shared constants and helpers for the pipelined array multiplier.
// Holds the legal parameter bounds and the stage-count arithmetic so the
// top level and any wrappers agree on the pipeline depth.
package pipelined_array_mult_pkg;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;
  localparam int ROWS_MIN  = 1;

  // Integer ceiling division for positive operands.
  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

  // Number of row stages needed to cover all partial-product rows.
  function automatic int num_stages(input int width, input int rows_per_stage);
    return ceil_div(width, rows_per_stage);
  endfunction

endpackage

// File: rtl/mult_row_stage.sv
// Purpose: adds a contiguous group of partial-product rows to an accumulator.
// Latency: purely combinational; the caller registers the result.
// Backpressure: none here; the enclosing pipeline stalls all stages together.
module mult_row_stage
  import pipelined_array_mult_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int FIRST_ROW = 0,
  parameter int NUM_ROWS  = 1
) (
  input  logic [NUM_ROWS-1:0]  a_rows_i,
  input  logic [WIDTH-1:0]     b_i,
  input  logic                 sgn_i,
  input  logic [2*WIDTH-1:0]   acc_i,
  output logic [2*WIDTH-1:0]   acc_o
);

  localparam int PW = 2 * WIDTH;

  // Multiplier widened once; sign extension only matters in signed mode.
  logic [PW-1:0] b_ext;
  assign b_ext = {{WIDTH{sgn_i & b_i[WIDTH-1]}}, b_i};

  // Running sum through the rows handled by this stage.
  logic [PW-1:0] psum [0:NUM_ROWS];
  assign psum[0] = acc_i;

  for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
    localparam int ROW = FIRST_ROW + r;
    logic [PW-1:0] row;
    assign row = a_rows_i[r] ? (b_ext << ROW) : '0;
    if (ROW == WIDTH - 1) begin : g_msb
      // The multiplicand MSB carries negative weight in two's complement.
      assign psum[r+1] = sgn_i ? (psum[r] - row) : (psum[r] + row);
    end else begin : g_plain
      assign psum[r+1] = psum[r] + row;
    end
  end

  assign acc_o = psum[NUM_ROWS];

endmodule

// File: rtl/pipelined_array_mult.sv
// Purpose: signed/unsigned WIDTH x WIDTH array multiplier, ROWS_PER_STAGE rows per stage.
// Latency: 1 + ceil(WIDTH/ROWS_PER_STAGE) cycles; one product per cycle sustained.
// Backpressure: whole pipe stalls when out_valid && !out_ready; in_ready = !out_valid || out_ready.
// Build option: define PARITY_OUT_EN to add the registered y_parity output.
module pipelined_array_mult
  import pipelined_array_mult_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int ROWS_PER_STAGE = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 sgn,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   y
`ifdef PARITY_OUT_EN
  ,
  output logic                 y_parity
`endif
);

  localparam int STAGES = num_stages(WIDTH, ROWS_PER_STAGE);
  localparam int PW     = 2 * WIDTH;

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX ||
      ROWS_PER_STAGE < ROWS_MIN || ROWS_PER_STAGE > WIDTH) begin : g_param_check
    $error("pipelined_array_mult: illegal WIDTH=%0d / ROWS_PER_STAGE=%0d",
           WIDTH, ROWS_PER_STAGE);
  end

  // Index 0 is the input register; index k+1 is the output of row stage k.
  logic             vld_q [0:STAGES];
  logic [WIDTH-1:0] a_q   [0:STAGES-1];
  logic [WIDTH-1:0] b_q   [0:STAGES-1];
  logic             sgn_q [0:STAGES-1];
  logic [PW-1:0]    acc_q [1:STAGES];
  logic [PW-1:0]    acc_in [0:STAGES-1];
  logic [PW-1:0]    acc_d  [0:STAGES-1];
  logic             adv;

  // Single global enable: the pipe moves only when the output slot can drain.
  assign adv       = !vld_q[STAGES] || out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_q[STAGES];
  assign y         = acc_q[STAGES];
  assign acc_in[0] = '0;

  // Input register: capture operands (and a bubble when in_valid is low).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q[0] <= 1'b0;
      a_q[0]   <= '0;
      b_q[0]   <= '0;
      sgn_q[0] <= 1'b0;
    end else if (adv) begin
      vld_q[0] <= in_valid;
      a_q[0]   <= a;
      b_q[0]   <= b;
      sgn_q[0] <= sgn;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int FR = k * ROWS_PER_STAGE;
    localparam int NR = (WIDTH - FR < ROWS_PER_STAGE) ? (WIDTH - FR) : ROWS_PER_STAGE;

    if (k > 0) begin : g_acc_in
      assign acc_in[k] = acc_q[k];
    end

    mult_row_stage #(
      .WIDTH     (WIDTH),
      .FIRST_ROW (FR),
      .NUM_ROWS  (NR)
    ) u_row (
      .a_rows_i (a_q[k][FR +: NR]),
      .b_i      (b_q[k]),
      .sgn_i    (sgn_q[k]),
      .acc_i    (acc_in[k]),
      .acc_o    (acc_d[k])
    );

    // Stage register for the valid bit and the partial accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q[k+1] <= 1'b0;
        acc_q[k+1] <= '0;
      end else if (adv) begin
        vld_q[k+1] <= vld_q[k];
        acc_q[k+1] <= acc_d[k];
      end
    end

    // Operands travel with the accumulator; the last stage no longer needs them.
    if (k < STAGES - 1) begin : g_ops
      // Operand carry register for the next row stage.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q[k+1]   <= '0;
          b_q[k+1]   <= '0;
          sgn_q[k+1] <= 1'b0;
        end else if (adv) begin
          a_q[k+1]   <= a_q[k];
          b_q[k+1]   <= b_q[k];
          sgn_q[k+1] <= sgn_q[k];
        end
      end
    end
  end

`ifdef PARITY_OUT_EN
  logic y_parity_q;
  // Parity is computed from the value about to enter y so both update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_parity_q <= 1'b0;
    end else if (adv) begin
      y_parity_q <= ^acc_d[STAGES-1];
    end
  end
  assign y_parity = y_parity_q;
`endif

endmodule

// File: tb/tb_pipelined_array_mult.sv
module tb_pipelined_array_mult;

  localparam int W   = 8;
  localparam int LAT = 5;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           sgn;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] y;
`ifdef PARITY_OUT_EN
  logic           y_parity;
`endif

  pipelined_array_mult #(.WIDTH(W), .ROWS_PER_STAGE(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sgn       (sgn),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y)
`ifdef PARITY_OUT_EN
    ,
    .y_parity  (y_parity)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2*W-1:0] y;
    int             acc_cyc;
  } exp_t;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           sgn;
    logic [2*W-1:0] exp_y;
  } vec_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  bit   chk_lat  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference product from plain integer arithmetic.
  function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] x, input logic [W-1:0] z,
                                               input logic s);
    longint px, pz, p;
    if (s) begin
      px = longint'($signed(x));
      pz = longint'($signed(z));
    end else begin
      px = longint'(x);
      pz = longint'(z);
    end
    p = px * pz;
    return p[2*W-1:0];
  endfunction

  // One clock cycle: drive inputs, score both handshakes, advance to just after the edge.
  task automatic cycle(input bit iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input bit is, input bit ordy,
                       input bit use_ey = 1'b0, input logic [2*W-1:0] ey = '0);
    exp_t e;
    in_valid  = iv;
    a         = ia;
    b         = ib;
    sgn       = is;
    out_ready = ordy;
    #1;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 64'(out_valid), 64'(0));
      end else begin
        e = exp_q.pop_front();
        check("y", 64'(y), 64'(e.y));
`ifdef PARITY_OUT_EN
        check("y_parity", 64'(y_parity), 64'(^e.y));
`endif
        if (chk_lat) check("latency", 64'(cyc - e.acc_cyc), 64'(LAT));
      end
    end
    if (in_valid && in_ready) begin
      e.y       = use_ey ? ey : ref_prod(ia, ib, is);
      e.acc_cyc = cyc;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      cycle(1'b0, '0, '0, 1'b0, 1'b1);
      n++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'(0));
    repeat (3) cycle(1'b0, '0, '0, 1'b0, 1'b1);
  endtask

  vec_t vecs[8];
  logic [2*W-1:0] y_hold;

  initial begin
    vecs[0] = '{a: 8'd13,  b: 8'd11,  sgn: 1'b0, exp_y: 16'h008F};
    vecs[1] = '{a: 8'hFF,  b: 8'hFF,  sgn: 1'b0, exp_y: 16'hFE01};
    vecs[2] = '{a: 8'hFF,  b: 8'hFF,  sgn: 1'b1, exp_y: 16'h0001};
    vecs[3] = '{a: 8'h80,  b: 8'h80,  sgn: 1'b1, exp_y: 16'h4000};
    vecs[4] = '{a: 8'h80,  b: 8'h01,  sgn: 1'b1, exp_y: 16'hFF80};
    vecs[5] = '{a: 8'h7F,  b: 8'h80,  sgn: 1'b1, exp_y: 16'hC080};
    vecs[6] = '{a: 8'h00,  b: 8'h55,  sgn: 1'b1, exp_y: 16'h0000};
    vecs[7] = '{a: 8'h80,  b: 8'h80,  sgn: 1'b0, exp_y: 16'h4000};

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; sgn = 1'b0; out_ready = 1'b1;
    #1;
    check("reset_out_valid", 64'(out_valid), 64'(0));
    check("reset_in_ready", 64'(in_ready), 64'(1));
    check("reset_y", 64'(y), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready_held", 64'(in_ready), 64'(1));
    rst_n = 1'b1;

    // Directed vectors one at a time, with exact latency.
    chk_lat = 1'b1;
    foreach (vecs[i]) begin
      cycle(1'b1, vecs[i].a, vecs[i].b, vecs[i].sgn, 1'b1, 1'b1, vecs[i].exp_y);
      check("no_early_valid", 64'(out_valid), 64'(0));
      drain();
    end

    // Back-to-back stream of 10 with out_ready high: exact latency means no gaps.
    for (int i = 0; i < 10; i++)
      cycle(1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'b1);
    drain();

    // Stall with a full pipe: nothing moves, nothing lost or duplicated.
    chk_lat = 1'b0;
    for (int i = 0; i < 7; i++)
      cycle(1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'b1);
    check("stall_pre_valid", 64'(out_valid), 64'(1));
    y_hold = y;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'b0);
      check("stall_in_ready", 64'(in_ready), 64'(0));
      check("stall_out_valid", 64'(out_valid), 64'(1));
      check("stall_y", 64'(y), 64'(y_hold));
    end
    drain();

    // Reset with three products in flight.
    for (int i = 0; i < 3; i++)
      cycle(1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'b1);
    cycle(1'b0, '0, '0, 1'b0, 1'b1);
    cycle(1'b0, '0, '0, 1'b0, 1'b1);
    check("pre_reset_valid", 64'(out_valid), 64'(1));
    rst_n = 1'b0;
    #1;
    check("mid_reset_out_valid", 64'(out_valid), 64'(0));
    check("mid_reset_y", 64'(y), 64'(0));
    check("mid_reset_in_ready", 64'(in_ready), 64'(1));
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, '0, '0, 1'b0, 1'b1);
      check("post_reset_idle", 64'(out_valid), 64'(0));
    end
    chk_lat = 1'b1;
    cycle(1'b1, 8'd13, 8'd11, 1'b0, 1'b1);
    drain();

    // Randomised traffic with random backpressure.
    chk_lat = 1'b0;
    for (int i = 0; i < 300; i++)
      cycle(bit'($urandom_range(0, 9) < 7), W'($urandom), W'($urandom),
            1'($urandom), bit'($urandom_range(0, 9) < 6));
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipelined_array_mult.md
PIPELINED_ARRAY_MULT -- requirements
Module: pipelined_array_mult

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand width in bits, legal range 2..32.
REQ-002 SHALL have parameter ROWS_PER_STAGE, default 2: partial-product rows accumulated per pipeline stage, legal range 1..WIDTH.
REQ-003 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1 bit: operands valid.
REQ-006 SHALL have port in_ready, output, 1 bit: block accepts operands this cycle.
REQ-007 SHALL have port a, input, WIDTH bits: multiplicand.
REQ-008 SHALL have port b, input, WIDTH bits: multiplier.
REQ-009 SHALL have port sgn, input, 1 bit: 1 = a, b and the product are two's complement; 0 = unsigned.
REQ-010 SHALL have port out_valid, output, 1 bit: product valid.
REQ-011 SHALL have port out_ready, input, 1 bit: consumer accepts the product.
REQ-012 SHALL have port y, output, 2*WIDTH bits: product.
REQ-013 SHALL have port y_parity, output, 1 bit: XOR-reduction of y; present only with PARITY_OUT_EN.

Function
REQ-014 SHALL define STAGES = ceil(WIDTH/ROWS_PER_STAGE) and latency = 1 + STAGES cycles: 1 input-register stage, then STAGES row stages.
REQ-015 SHALL define global advance enable adv = !out_valid || out_ready, and drive in_ready = adv.
REQ-016 SHALL transfer an input when in_valid && in_ready, and an output when out_valid && out_ready.
REQ-017 SHALL, when adv=0, hold every pipeline register, valid bit, y and out_valid unchanged.
REQ-018 SHALL advance all stages together when adv=1; bubbles (valid=0) propagate and are not collapsed.
REQ-019 SHALL, in stage k, add rows k*ROWS_PER_STAGE .. min((k+1)*ROWS_PER_STAGE, WIDTH)-1 to the incoming accumulator; row i = (a[i] ? b<<i : 0), formed at 2*WIDTH bits.
REQ-020 SHALL, when sgn=1, sign-extend b in every row and subtract row WIDTH-1 instead of adding it, giving the exact 2*WIDTH-bit two's-complement product.
REQ-021 SHALL carry a, b and sgn alongside the accumulator through every stage.
REQ-022 SHALL use modulo-2^(2*WIDTH) arithmetic; the result never overflows, including -2^(WIDTH-1) * -2^(WIDTH-1).
REQ-023 SHALL sustain a throughput of one product per cycle while out_ready=1.

Reset
REQ-024 SHALL, while rst_n=0, asynchronously clear all valid bits, out_valid, y, and y_parity (when present) to 0.
REQ-025 SHALL drive in_ready = 1 during and after reset, because out_valid = 0.
REQ-026 SHALL, on reset mid-operation, discard every in-flight product; no stale output appears after rst_n rises.
REQ-027 SHALL leave data registers other than y clear on reset; their values are don't-care while the matching valid bit = 0.

Configuration
REQ-028 SHALL, with PARITY_OUT_EN defined, register y_parity = ^y together with y and hold it under stall like y.
REQ-029 SHALL, without PARITY_OUT_EN, omit port y_parity and its register; all other behaviour is identical.

Structure
REQ-030 SHALL place the ceil-division function, a STAGES helper function, and the legal parameter bounds in package pipelined_array_mult_pkg.
REQ-031 SHALL implement one row stage as sub-module mult_row_stage, parameters WIDTH, FIRST_ROW, NUM_ROWS, instantiated STAGES times by a generate loop.
REQ-032 SHALL check parameter legality at elaboration and stop with an error when illegal.

Verification
(Default parameters: latency 5.)
REQ-033 SHALL cover: a=13, b=11, sgn=0, single pulse -> y=0x008F, out_valid exactly 5 cycles after acceptance, y_parity=1.
REQ-034 SHALL cover: a=0xFF, b=0xFF -> with sgn=0, y=0xFE01; with sgn=1, y=0x0001.
REQ-035 SHALL cover: a=0x80, b=0x80, sgn=1 -> y=0x4000; a=0x80, b=0x01, sgn=1 -> y=0xFF80.
REQ-036 SHALL cover: back-to-back stream of 10 operand pairs with out_ready=1 -> 10 consecutive products in order, no gaps.
REQ-037 SHALL cover: pipeline full, out_ready=0 for 3 cycles -> in_ready=0, y and out_valid stable, no loss or duplication after release.
REQ-038 SHALL cover: rst_n low for 1 cycle with 3 products in flight -> out_valid=0 immediately; no output until a new input is accepted.
